// File: rtl/trng_word_packer.sv
// rtl/trng_word_packer.sv - packs the TRNG bit stream into words behind a small valid/ready FIFO; optional repetition-count health test under TRNG_REPCNT_EN
module trng_word_packer #(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int DISCARD    = 64,
    parameter int REP_LIMIT  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            output_en,
    input  logic                            bit_in,
    input  logic                            bit_sample,
    output logic [WORD_W-1:0]               m_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic                            overflow,
    input  logic                            clear_ovf,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            health_fail
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(WORD_W);
    localparam int DW = (DISCARD > 1) ? $clog2(DISCARD) : 1;
    localparam logic [BW-1:0] BCNT_LAST  = BW'(WORD_W - 1);
    localparam logic [DW-1:0] DCNT_LAST  = DW'((DISCARD > 0) ? DISCARD - 1 : 0);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISCARD,
        S_COLLECT
    } state_t;

    state_t            state_q;
    logic [DW-1:0]     dcnt_q;
    logic [BW-1:0]     bcnt_q;
    logic [WORD_W-1:0] shreg_q;
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_q;
    logic [PW-1:0]     rd_q;
    logic [LW-1:0]     level_q;
    logic [LW-1:0]     level_d;
    logic              valid_q;
    logic              ovf_q;

    logic              sample;
    logic              pop;
    logic              full;
    logic              word_done;
    logic              push;
    logic              drop;
    logic              health_block;
    logic [WORD_W-1:0] new_word;

    assign sample = output_en & bit_sample;

`ifdef TRNG_REPCNT_EN
    localparam int RW = $clog2(REP_LIMIT + 1);

    logic [RW-1:0] run_q;
    logic [RW-1:0] run_d;
    logic          last_q;
    logic          health_q;
    logic          health_d;

    // Length of the current run of identical sampled bits; reaching REP_LIMIT latches the failure
    always_comb begin
        run_d    = run_q;
        health_d = health_q;
        if (state_q != S_IDLE && sample) begin
            if (run_q == '0 || bit_in != last_q) begin
                run_d = RW'(1);
            end else if (run_q != RW'(REP_LIMIT)) begin
                run_d = run_q + RW'(1);
            end
            if (run_d == RW'(REP_LIMIT)) begin
                health_d = 1'b1;
            end
        end
    end

    // Run counter restarts whenever output_en drops (FSM heads to IDLE); failure flag only clears on rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q    <= '0;
            last_q   <= 1'b0;
            health_q <= 1'b0;
        end else begin
            health_q <= health_d;
            if (!output_en) begin
                run_q <= '0;
            end else begin
                run_q <= run_d;
                if (sample) begin
                    last_q <= bit_in;
                end
            end
        end
    end

    // The failing sample itself already suppresses any word it would complete
    assign health_block = health_d;
    assign health_fail  = health_q;
`else
    assign health_block = 1'b0;
    // Constant 0 for any legal REP_LIMIT
    assign health_fail  = (REP_LIMIT < 0);
`endif

    // Word completion and FIFO push/pop decisions for this edge
    always_comb begin
        new_word  = {shreg_q[WORD_W-2:0], bit_in};
        full      = (level_q == LEVEL_FULL);
        pop       = valid_q & m_ready;
        word_done = (state_q == S_COLLECT) && sample && (bcnt_q == BCNT_LAST) && !health_block;
        push      = word_done && (!full || pop);
        drop      = word_done && full && !pop;
        level_d   = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    // Sequencing FSM, bit packing, and FIFO storage/pointers/status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            dcnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (output_en) begin
                        state_q <= (DISCARD == 0) ? S_COLLECT : S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (!output_en) begin
                        state_q <= S_IDLE;
                        dcnt_q  <= '0;
                    end else if (sample) begin
                        if (dcnt_q == DCNT_LAST) begin
                            state_q <= S_COLLECT;
                            dcnt_q  <= '0;
                        end else begin
                            dcnt_q <= dcnt_q + DW'(1);
                        end
                    end
                end
                S_COLLECT: begin
                    if (!output_en) begin
                        state_q <= S_IDLE;
                        bcnt_q  <= '0;
                    end else if (sample) begin
                        shreg_q <= new_word;
                        bcnt_q  <= (bcnt_q == BCNT_LAST) ? '0 : bcnt_q + BW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (push) begin
                mem_q[wr_q] <= new_word;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PW'(1);
            end
            level_q <= level_d;
            valid_q <= (level_d != '0);

            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clear_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign m_data     = mem_q[rd_q];
    assign m_valid    = valid_q;
    assign overflow   = ovf_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_trng_word_packer.sv
// tb/tb_trng_word_packer.sv - self-checking bench for trng_word_packer (WORD_W=8, FIFO_DEPTH=4, DISCARD=4)
`timescale 1ns/1ps
module tb_trng_word_packer;
    localparam int WORD_W = 8;
    localparam int DEPTH  = 4;
    localparam int DISC   = 4;
    localparam int RLIM   = 16;

    logic              clk        = 1'b0;
    logic              rst        = 1'b1;
    logic              output_en  = 1'b0;
    logic              bit_in     = 1'b0;
    logic              bit_sample = 1'b0;
    logic              m_ready    = 1'b0;
    logic              clear_ovf  = 1'b0;
    logic [WORD_W-1:0] m_data;
    logic              m_valid;
    logic              overflow;
    logic              health_fail;
    logic [2:0]        fifo_level;

    int n_pass  = 0;
    int n_total = 0;
    bit rand_rdy = 0;

    always #5 clk = ~clk;

    trng_word_packer #(
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (DEPTH),
        .DISCARD    (DISC),
        .REP_LIMIT  (RLIM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .output_en   (output_en),
        .bit_in      (bit_in),
        .bit_sample  (bit_sample),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .overflow    (overflow),
        .clear_ovf   (clear_ovf),
        .fifo_level  (fifo_level),
        .health_fail (health_fail)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: words are built from the run of qualified bits that follows DISC discarded ones.
    // A bit counts only if output_en was also high at the previous edge (the first enabled cycle is IDLE).
    logic [WORD_W-1:0] mq[$];
    bit                bits[$];
    int                nseen  = 0;
    int                run    = 0;
    bit                en_prev = 0;
    bit                ovf_m  = 0;
    bit                hf_m   = 0;
    bit                last_b = 0;
    bit                stall_prev = 0;
    logic [WORD_W-1:0] data_prev = '0;

    initial forever begin
        bit                popm;
        bit                done;
        logic [WORD_W-1:0] w;
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete(); bits.delete();
            nseen = 0; run = 0; en_prev = 0; ovf_m = 0; hf_m = 0; stall_prev = 0;
        end else begin
            stall_prev = (m_valid === 1'b1) && (m_ready === 1'b0);
            data_prev  = m_data;
            popm = (mq.size() != 0) && m_ready;
            done = 0;
            w    = '0;
            if (!output_en) begin
                bits.delete(); nseen = 0; run = 0;
            end else if (en_prev && bit_sample) begin
                run    = (run != 0 && bit_in == last_b) ? run + 1 : 1;
                last_b = bit_in;
`ifdef TRNG_REPCNT_EN
                if (run >= RLIM) hf_m = 1;
`endif
                if (nseen < DISC) nseen++;
                else begin
                    bits.push_back(bit_in);
                    if (bits.size() == WORD_W) begin
                        foreach (bits[i]) w = {w[WORD_W-2:0], bits[i]};
                        bits.delete();
                        done = !hf_m;
                    end
                end
            end
            if (popm) void'(mq.pop_front());
            if (done && mq.size() >= DEPTH) ovf_m = 1;
            else begin
                if (done) mq.push_back(w);
                if (clear_ovf) ovf_m = 0;
            end
            en_prev = output_en;
        end
    end

    // Per-cycle comparison of DUT outputs against the model, sampled mid-cycle
    initial forever begin
        @(negedge clk);
        check("m_valid", m_valid, mq.size() != 0);
        check("fifo_level", fifo_level, mq.size());
        check("overflow", overflow, ovf_m);
        check("health_fail", health_fail, hf_m);
        if (mq.size() != 0) check("m_data", m_data, mq[0]);
        if (stall_prev && !rst) check("m_data_stable", m_data, data_prev);
    end

    initial forever begin
        @(negedge clk);
        if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
    end

    task automatic step(input bit en, input bit bs, input bit b);
        output_en = en; bit_sample = bs; bit_in = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [WORD_W-1:0] v, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            step(1, 1, v[WORD_W-1-i]);
            if (gaps) step(1, 0, ~v[WORD_W-1-i]);
        end
    endtask

    task automatic drain(input logic [WORD_W-1:0] e0, input logic [WORD_W-1:0] e1,
                         input logic [WORD_W-1:0] e2, input logic [WORD_W-1:0] e3, input int n);
        logic [WORD_W-1:0] exp [4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        m_ready = 1;
        for (int i = 0; i < n; i++) begin
            check("drain_word", m_data, exp[i]);
            step(1, 0, 0);
        end
        m_ready = 0;
        check("drain_empty", m_valid, 0);
    endtask

    initial begin
        int budget;
        repeat (2) @(negedge clk);
        rst = 0;
        check("rst_m_valid", m_valid, 0);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_m_data", m_data, 0);
        check("rst_health", health_fail, 0);

        // Warm-up: IDLE cycle bit ignored, 4 discarded ones, then 1011_0010
        step(1, 1, 0);
        send(8'hF0, 4, 0);
        send(8'hB2, 7, 0);
        check("warm_no_valid_yet", m_valid, 0);
        step(1, 1, 0);
        check("warm_valid", m_valid, 1);
        check("warm_data", m_data, 8'hB2);
        check("warm_level", fifo_level, 1);

        // Gated sampling: gaps carry inverted garbage bits
        send(8'hB2, 8, 1);
        check("gap_level", fifo_level, 2);

        // Abort after 5 bits, re-enable, re-discard 1010, then 5C
        send(8'hE8, 5, 0);
        step(0, 1, 1);
        step(1, 1, 1);
        send(8'hA0, 4, 0);
        send(8'h5C, 8, 0);
        check("abort_level", fifo_level, 3);
        drain(8'hB2, 8'hB2, 8'h5C, 8'h00, 3);

        // Overflow with five words against a stalled consumer
        for (int k = 1; k <= 5; k++) send(WORD_W'(k), 8, 0);
        check("ovf_level", fifo_level, 4);
        check("ovf_set", overflow, 1);
        check("ovf_head", m_data, 8'h01);
        clear_ovf = 1;
        step(1, 0, 0);
        clear_ovf = 0;
        check("ovf_cleared", overflow, 0);
        send(8'h06, 7, 0);
        m_ready = 1;
        step(1, 1, 0);
        m_ready = 0;
        check("full_pushpop_level", fifo_level, 4);
        check("full_pushpop_ovf", overflow, 0);
        check("full_pushpop_head", m_data, 8'h02);
        send(8'h07, 7, 0);
        clear_ovf = 1;
        step(1, 1, 1);
        clear_ovf = 0;
        check("ovf_set_wins", overflow, 1);
        drain(8'h02, 8'h03, 8'h04, 8'h06, 4);
        clear_ovf = 1;
        step(1, 0, 0);
        clear_ovf = 0;

        // Random backpressure
        rand_rdy = 1;
        send(8'h96, 8, 0); send(8'h69, 8, 0); send(8'hA5, 8, 0);
        send(8'h3C, 8, 0); send(8'hC3, 8, 0); send(8'h5A, 8, 0);
        budget = 0;
        while (m_valid && budget < 200) begin
            step(1, 0, 0);
            budget++;
        end
        rand_rdy = 0;
        m_ready  = 0;
        check("bp_drained", m_valid, 0);

`ifdef TRNG_REPCNT_EN
        output_en = 0;
        rst = 1; @(negedge clk); rst = 0;
        step(1, 1, 1);
        send(8'h50, 4, 0);
        for (int i = 0; i < 15; i++) step(1, 1, 0);
        check("hf_before_16th", health_fail, 0);
        step(1, 1, 0);
        check("hf_on_16th", health_fail, 1);
        check("hf_level", fifo_level, 1);
        check("hf_head", m_data, 8'h00);
        send(8'hA5, 8, 0);
        check("hf_no_push", fifo_level, 1);
        drain(8'h00, 8'h00, 8'h00, 8'h00, 1);
        step(1, 0, 0);
        check("hf_sticky", health_fail, 1);
        output_en = 0;
        rst = 1; @(negedge clk); rst = 0;
        check("hf_rst_clears", health_fail, 0);
`else
        check("hf_tied_low", health_fail, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
